// File: rtl/psum_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : psum_writeback
//  Description : Buffers post-ReLU partial-sum rows in a small FIFO and writes
//                them to consecutive SRAM rows starting at a job base address.
//                The SRAM port is arbitrated by sram_gnt; rows that arrive
//                while the FIFO is full are dropped and flagged via overflow.
//  Revision    : 1.0  initial release
// ============================================================================
module psum_writeback #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int ADDR_BW = 11,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_BW-1:0]       base_addr,
  input  logic [ADDR_BW-1:0]       num_rows,
  input  logic                     valid_in,
  input  logic [PSUM_BW*COL-1:0]   in,
  input  logic                     sram_gnt,
  output logic                     sram_cen,
  output logic                     sram_wen,
  output logic [ADDR_BW-1:0]       sram_addr,
  output logic [PSUM_BW*COL-1:0]   sram_d,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [ADDR_BW-1:0]       written
);

  localparam int                 c_DATA_W = PSUM_BW * COL;
  localparam int                 c_PTR_W  = $clog2(DEPTH);
  localparam logic [c_PTR_W:0]   c_FULL   = (c_PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [c_DATA_W-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0]    r_wptr;
  logic [c_PTR_W-1:0]    r_rptr;
  logic [c_PTR_W:0]      r_count;
  logic [c_PTR_W:0]      w_count_next;

  logic [ADDR_BW-1:0]    r_addr;
  logic [ADDR_BW-1:0]    r_target;
  logic [ADDR_BW-1:0]    r_written;
  logic [ADDR_BW-1:0]    r_accepted;
  logic [ADDR_BW-1:0]    w_written_next;
  logic [ADDR_BW-1:0]    w_accepted_next;
  logic                  r_overflow;

  logic                  w_start;
  logic                  w_req;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_push_try;
  logic                  w_push;
  logic                  w_drop;

  // start is only honoured from IDLE; elsewhere it is ignored entirely
  assign w_start    = (r_state == S_IDLE) && start;
  // a request is presented combinationally from the FIFO head while running
  assign w_req      = (r_state == S_RUN) && (r_count != '0);
  assign w_pop      = w_req && sram_gnt;
  assign w_full     = (r_count == c_FULL);
  // every valid row within the job quota counts as accepted, stored or not
  assign w_push_try = (r_state == S_RUN) && valid_in && (r_accepted < r_target);
  // a same-cycle pop frees the slot, so a full FIFO can still take the row
  assign w_push     = w_push_try && (!w_full || w_pop);
  assign w_drop     = w_push_try && w_full && !w_pop;

  assign w_written_next  = r_written  + {{(ADDR_BW-1){1'b0}}, w_pop};
  assign w_accepted_next = r_accepted + {{(ADDR_BW-1){1'b0}}, w_push_try};

  // FIFO occupancy after this edge
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // next-state logic; a job with dropped rows ends once nothing is left to write
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (num_rows == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if ((w_written_next == r_target) ||
            ((w_accepted_next == r_target) && (w_count_next == '0))) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // job fields, FIFO pointers and progress counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr     <= '0;
      r_target   <= '0;
      r_written  <= '0;
      r_accepted <= '0;
      r_overflow <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else if (w_start) begin
      r_addr     <= base_addr;
      r_target   <= num_rows;
      r_written  <= '0;
      r_accepted <= '0;
      r_overflow <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_addr <= r_addr + 1'b1;
      end
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      r_written  <= w_written_next;
      r_accepted <= w_accepted_next;
      r_count    <= w_count_next;
    end
  end

  // FIFO storage; contents are only observed through a valid head pointer
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in;
    end
  end

  assign sram_cen  = ~w_req;
  assign sram_wen  = ~w_req;
  assign sram_addr = r_addr;
  // data is forced to zero while idle so the bus is clean after reset
  assign sram_d    = w_req ? r_mem[r_rptr] : '0;
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign overflow  = r_overflow;
  assign written   = r_written;

endmodule
`default_nettype wire
